// File: rtl/img_stream_framer_pkg.sv
// Shared types and helpers for the image stream framer and its checksum block.
package img_stream_framer_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXELS,
    ST_CKSUM0,
    ST_CKSUM1,
    ST_PAD,
    ST_DONE
  } state_t;

  // Fletcher-32 works modulo 2^16-1; kept 17 bits wide to match the adder
  localparam logic [16:0] FLETCHER_MOD = 17'd65535;

  // Host order to wire order (little-endian on the wire)
  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/img_stream_framer_fletcher32_accum.sv
// Fletcher-32 running sums over 16-bit words; one word per enabled cycle.
module fletcher32_accum
  import img_stream_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] din,
  output logic [31:0] sum
);

  logic [15:0] s1_q, s1_d;
  logic [15:0] s2_q, s2_d;
  logic [16:0] s1_add, s1_sub;
  logic [16:0] s2_add, s2_sub;
  logic [15:0] s1_new;

  // Modular update: 17-bit add then one conditional subtract, so 65535 folds to 0
  always_comb begin
    s1_add = {1'b0, s1_q} + {1'b0, din};
    s1_sub = s1_add - FLETCHER_MOD;
    s1_new = (s1_add >= FLETCHER_MOD) ? s1_sub[15:0] : s1_add[15:0];
    s2_add = {1'b0, s2_q} + {1'b0, s1_new};
    s2_sub = s2_add - FLETCHER_MOD;
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (clear) begin
      s1_d = '0;
      s2_d = '0;
    end else if (en) begin
      s1_d = s1_new;
      s2_d = (s2_add >= FLETCHER_MOD) ? s2_sub[15:0] : s2_add[15:0];
    end
  end

  // Sum registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign sum = {s2_q, s1_q};

endmodule

// File: rtl/img_stream_framer.sv
// Image word stream framer: header, (thumbnail-filtered) pixels, Fletcher-32, zero pad.
module img_stream_framer
  import img_stream_framer_pkg::*;
#(
  parameter int HeaderWordCount = 16,
  parameter int PadBlockWords   = 256,
  parameter int FilterPeriod    = 8,
  parameter int FilterKeep      = 2,
  parameter int DimBits         = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DimBits-1:0] cfg_width,
  input  logic [DimBits-1:0] cfg_height,
  input  logic               cfg_thumb,
  input  logic [15:0]        hdr_data,
  input  logic               hdr_valid,
  output logic               hdr_ready,
  input  logic [15:0]        pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [15:0]        wr_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done
);

  // Filter phase counters need at least one bit even for a period of 1
  localparam int              FW         = (FilterPeriod > 1) ? $clog2(FilterPeriod) : 1;
  localparam logic [FW-1:0]   PHASE_LAST = FW'(FilterPeriod - 1);
  localparam logic [FW:0]     PHASE_KEEP = (FW + 1)'(FilterKeep);
  localparam logic [15:0]     HDR_LAST   = 16'(HeaderWordCount - 1);
  localparam logic [15:0]     PAD_MASK   = 16'(PadBlockWords - 1);

  state_t             state_q, state_d;
  logic [DimBits-1:0] width_m1_q, width_m1_d;
  logic [DimBits-1:0] height_m1_q, height_m1_d;
  logic               thumb_q, thumb_d;
  logic [DimBits-1:0] x_q, x_d;
  logic [DimBits-1:0] y_q, y_d;
  logic [FW-1:0]      fx_q, fx_d;
  logic [FW-1:0]      fy_q, fy_d;
  logic [15:0]        hdr_cnt_q, hdr_cnt_d;
  // Only the low bits matter for block alignment, so wrap-around is harmless
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               wr_valid_q, wr_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               out_free;
  logic               keep;
  logic               last_pix;
  logic [15:0]        word_cnt_inc;
  logic               block_end;
  logic               acc_clear;
  logic               acc_en;
  logic [15:0]        acc_din;
  logic [31:0]        cs;

  fletcher32_accum u_cksum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .en    (acc_en),
    .din   (acc_din),
    .sum   (cs)
  );

  // Next-state, handshakes and output-register loading
  always_comb begin
    state_d     = state_q;
    width_m1_d  = width_m1_q;
    height_m1_d = height_m1_q;
    thumb_d     = thumb_q;
    x_d         = x_q;
    y_d         = y_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    hdr_cnt_d   = hdr_cnt_q;
    word_cnt_d  = word_cnt_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = wr_valid_q;
    done_d      = 1'b0;
    hdr_ready   = 1'b0;
    pix_ready   = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    acc_din     = 16'h0000;

    out_free     = !wr_valid_q || wr_ready;
    keep         = !thumb_q || (({1'b0, fx_q} < PHASE_KEEP) && ({1'b0, fy_q} < PHASE_KEEP));
    last_pix     = (x_q == width_m1_q) && (y_q == height_m1_q);
    word_cnt_inc = word_cnt_q + 16'd1;
    block_end    = (word_cnt_inc & PAD_MASK) == 16'd0;

    // A pending word drains when downstream takes it; a new load below overrides
    if (wr_valid_q && wr_ready) begin
      wr_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          width_m1_d  = cfg_width - 1'b1;
          height_m1_d = cfg_height - 1'b1;
          thumb_d     = cfg_thumb;
          x_d         = '0;
          y_d         = '0;
          fx_d        = '0;
          fy_d        = '0;
          hdr_cnt_d   = '0;
          word_cnt_d  = '0;
          acc_clear   = 1'b1;
          state_d     = (HeaderWordCount == 0) ? ST_PIXELS : ST_HEADER;
        end
      end
      ST_HEADER: begin
        hdr_ready = out_free;
        if (hdr_valid && out_free) begin
          wr_data_d  = bswap16(hdr_data);
          wr_valid_d = 1'b1;
          word_cnt_d = word_cnt_inc;
          acc_en     = 1'b1;
          acc_din    = hdr_data;
          hdr_cnt_d  = hdr_cnt_q + 16'd1;
          if (hdr_cnt_q == HDR_LAST) begin
            state_d = ST_PIXELS;
          end
        end
      end
      ST_PIXELS: begin
        // Dropped pixels never touch the output register, so they need no slot
        pix_ready = keep ? out_free : 1'b1;
        if (pix_valid && pix_ready) begin
          if (keep) begin
            wr_data_d  = bswap16(pix_data);
            wr_valid_d = 1'b1;
            word_cnt_d = word_cnt_inc;
            acc_en     = 1'b1;
            acc_din    = pix_data;
          end
          if (x_q == width_m1_q) begin
            x_d  = '0;
            fx_d = '0;
            y_d  = y_q + 1'b1;
            fy_d = (fy_q == PHASE_LAST) ? '0 : fy_q + 1'b1;
          end else begin
            x_d  = x_q + 1'b1;
            fx_d = (fx_q == PHASE_LAST) ? '0 : fx_q + 1'b1;
          end
          if (last_pix) begin
            state_d = ST_CKSUM0;
          end
        end
      end
      ST_CKSUM0: begin
        if (out_free) begin
          wr_data_d  = bswap16(cs[15:0]);
          wr_valid_d = 1'b1;
          word_cnt_d = word_cnt_inc;
          state_d    = ST_CKSUM1;
        end
      end
      ST_CKSUM1: begin
        if (out_free) begin
          wr_data_d  = bswap16(cs[31:16]);
          wr_valid_d = 1'b1;
          word_cnt_d = word_cnt_inc;
          state_d    = block_end ? ST_DONE : ST_PAD;
        end
      end
      ST_PAD: begin
        if (out_free) begin
          wr_data_d  = 16'h0000;
          wr_valid_d = 1'b1;
          word_cnt_d = word_cnt_inc;
          if (block_end) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Final word sits in the output register until downstream takes it
        if (wr_valid_q && wr_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      width_m1_q  <= '0;
      height_m1_q <= '0;
      thumb_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      hdr_cnt_q   <= '0;
      word_cnt_q  <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_m1_q  <= width_m1_d;
      height_m1_q <= height_m1_d;
      thumb_q     <= thumb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      hdr_cnt_q   <= hdr_cnt_d;
      word_cnt_q  <= word_cnt_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_img_stream_framer.sv
// Directed bench for img_stream_framer (2 header words, 8-word pad blocks).
module tb_img_stream_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic        cfg_thumb;
  logic [15:0] hdr_data;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] hdr_mem [0:1];
  logic [15:0] pix_mem [0:255];
  logic [15:0] out_q [$];
  int          done_cnt;
  int          stab_viol;
  int          pix_acc;
  bit          timed_out;

  always #5 clk = ~clk;

  img_stream_framer #(
    .HeaderWordCount (2),
    .PadBlockWords   (8),
    .FilterPeriod    (8),
    .FilterKeep      (2),
    .DimBits         (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_thumb  (cfg_thumb),
    .hdr_data   (hdr_data),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic drive_hdr(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      hdr_valid = 1'b1;
      hdr_data  = hdr_mem[i];
      #4;
      if (hdr_ready) i++;
      guard++;
    end
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic drive_pix(input int n, input bit gaps);
    int guard = 0;
    pix_acc = 0;
    while (pix_acc < n && guard < 4000) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data  = pix_mem[pix_acc];
      end
      #4;
      if (pix_valid && pix_ready) pix_acc++;
      guard++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // Runs one frame; collects accepted output words, done pulses and stall violations
  task automatic run_frame(input int w, input int h, input bit thumb,
                           input bit stall, input bit gaps, input bit poke);
    out_q.delete();
    done_cnt  = 0;
    stab_viol = 0;
    @(negedge clk);
    start      = 1'b1;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
    cfg_thumb  = thumb;
    @(negedge clk);
    start = 1'b0;
    fork
      drive_hdr(2);
      drive_pix(w * h, gaps);
      begin
        int post = 0;
        bit prev_stall = 1'b0;
        logic [15:0] prev_data = 16'h0;
        for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
          @(negedge clk);
          wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          #4;
          if (prev_stall && (wr_valid !== 1'b1 || wr_data !== prev_data)) stab_viol++;
          prev_stall = wr_valid && !wr_ready;
          prev_data  = wr_data;
          if (wr_valid && wr_ready) begin
            out_q.push_back(wr_data);
            $display("  wr word %0d = %h", out_q.size() - 1, wr_data);
          end
          if (done) done_cnt++;
          if (done_cnt > 0) post++;
        end
        timed_out = (done_cnt == 0);
      end
      begin
        if (poke) begin
          repeat (4) @(negedge clk);
          start      = 1'b1;
          cfg_width  = 12'd5;
          cfg_height = 12'd3;
          cfg_thumb  = ~thumb;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_thumb = 1'b0;
    hdr_data = '0; hdr_valid = 1'b0; pix_data = '0; pix_valid = 1'b0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hdr_ready !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got hdr %b pix %b expected 0 0", hdr_ready, pix_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [15:0] exp [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                             16'h0A00, 16'h1400, 16'h0000, 16'h0000};
    hdr_mem[0] = 16'h0001; hdr_mem[1] = 16'h0002;
    pix_mem[0] = 16'h0003; pix_mem[1] = 16'h0004;
    run_frame(2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: no done pulse"); end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL basic_word[%0d]: missing expected %h", i, exp[i]); end
      else if (out_q[i] !== exp[i]) begin errors++; $display("FAIL basic_word[%0d]: got %h expected %h", i, out_q[i], exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    $display("test_basic done");
  endtask

  task automatic test_wrap();
    logic [15:0] exp [8] = '{16'hFFFF, 16'h0100, 16'h0000, 16'h0100,
                             16'h0200, 16'h0000, 16'h0000, 16'h0000};
    hdr_mem[0] = 16'hFFFF; hdr_mem[1] = 16'h0001;
    pix_mem[0] = 16'h0000;
    run_frame(1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout: no done pulse"); end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL wrap_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL wrap_word[%0d]: missing expected %h", i, exp[i]); end
      else if (out_q[i] !== exp[i]) begin errors++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, out_q[i], exp[i]); end
    end
    $display("test_wrap done");
  endtask

  // Thumbnail frame; with stall=1 the same words must come out under backpressure and gaps
  task automatic test_thumb(input bit stall);
    logic [15:0] exp [24] = '{16'h0100, 16'h0200,
                              16'h0000, 16'h0100, 16'h0800, 16'h0900,
                              16'h1000, 16'h1100, 16'h1800, 16'h1900,
                              16'h8000, 16'h8100, 16'h8800, 16'h8900,
                              16'h9000, 16'h9100, 16'h9800, 16'h9900,
                              16'hCB04, 16'h9417,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    hdr_mem[0] = 16'h0001; hdr_mem[1] = 16'h0002;
    for (int i = 0; i < 256; i++) pix_mem[i] = 16'(i);
    run_frame(16, 16, 1'b1, stall, stall, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL thumb_timeout(stall=%0d): no done pulse", stall); end
    checks++; if (pix_acc != 256) begin errors++; $display("FAIL thumb_pix_accepted: got %0d expected 256", pix_acc); end
    checks++; if (out_q.size() != 24) begin errors++; $display("FAIL thumb_count: got %0d expected 24", out_q.size()); end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL thumb_word[%0d]: missing expected %h", i, exp[i]); end
      else if (out_q[i] !== exp[i]) begin errors++; $display("FAIL thumb_word[%0d]: got %h expected %h", i, out_q[i], exp[i]); end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL thumb_stall_stability: got %0d changes expected 0", stab_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL thumb_done_pulses: got %0d expected 1", done_cnt); end
    $display("test_thumb(stall=%0d) done", stall);
  endtask

  // Exactly one block: no pad words; a mid-frame start with other cfg is ignored
  task automatic test_align();
    logic [15:0] exp [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                             16'h0500, 16'h0600, 16'h1500, 16'h3800};
    hdr_mem[0] = 16'h0001; hdr_mem[1] = 16'h0002;
    pix_mem[0] = 16'h0003; pix_mem[1] = 16'h0004; pix_mem[2] = 16'h0005; pix_mem[3] = 16'h0006;
    run_frame(2, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (timed_out) begin errors++; $display("FAIL align_timeout: no done pulse"); end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL align_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL align_word[%0d]: missing expected %h", i, exp[i]); end
      else if (out_q[i] !== exp[i]) begin errors++; $display("FAIL align_word[%0d]: got %h expected %h", i, out_q[i], exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL align_done_pulses: got %0d expected 1", done_cnt); end
    $display("test_align done");
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [8] = '{16'h3412, 16'h0100, 16'h0300, 16'h0400,
                             16'h3C12, 16'hDD48, 16'h0000, 16'h0000};
    @(negedge clk);
    start = 1'b1; cfg_width = 12'd4; cfg_height = 12'd4; cfg_thumb = 1'b0;
    hdr_valid = 1'b1; hdr_data = 16'hBEEF; pix_valid = 1'b1; pix_data = 16'h7777; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #4;
    checks++; if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_pixels: got busy %b pix_ready %b expected 1 1", busy, pix_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hdr_valid = 1'b0; pix_valid = 1'b0;
    #4;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL midrst_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    hdr_mem[0] = 16'h1234; hdr_mem[1] = 16'h0001;
    pix_mem[0] = 16'h0003; pix_mem[1] = 16'h0004;
    run_frame(2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL midrst_timeout: no done pulse"); end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL midrst_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL midrst_word[%0d]: missing expected %h", i, exp[i]); end
      else if (out_q[i] !== exp[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %h expected %h", i, out_q[i], exp[i]); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_thumb(1'b0);
    test_thumb(1'b1);
    test_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
